// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: bus configuration, response codes, and the command/response
// records used by the single-outstanding command master.
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned A;
    int unsigned N;
  } axi4_lite_cfg_t;

  localparam int unsigned AXI4_LITE_A = 16;
  localparam int unsigned AXI4_LITE_N = 4;
  localparam axi4_lite_cfg_t AXI4_LITE_CFG = '{A: AXI4_LITE_A, N: AXI4_LITE_N};

  typedef logic [1:0] axi4_lite_resp_t;

  localparam axi4_lite_resp_t OKAY   = 2'b00;
  localparam axi4_lite_resp_t EXOKAY = 2'b01;
  localparam axi4_lite_resp_t SLVERR = 2'b10;
  localparam axi4_lite_resp_t DECERR = 2'b11;

  typedef struct packed {
    logic                          write;
    logic [AXI4_LITE_CFG.A-1:0]    addr;
    logic [AXI4_LITE_CFG.N*8-1:0]  wdata;
    logic [AXI4_LITE_CFG.N-1:0]    wstrb;
  } axi4_lite_cmd_t;

  typedef struct packed {
    logic                          write;
    logic [AXI4_LITE_CFG.N*8-1:0]  rdata;
    axi4_lite_resp_t               resp;
  } axi4_lite_rsp_t;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI4-Lite
// transaction out, one response back. Slave responses are passed through untouched.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned A = AXI4_LITE_A,
  parameter int unsigned N = AXI4_LITE_N
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [A-1:0]   cmd_addr,
  input  logic [N*8-1:0] cmd_wdata,
  input  logic [N-1:0]   cmd_wstrb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_write,
  output logic [N*8-1:0] rsp_rdata,
  output logic [1:0]     rsp_resp,
  output logic [A-1:0]   awaddr,
  output logic [2:0]     awprot,
  output logic           awvalid,
  input  logic           awready,
  output logic [N*8-1:0] wdata,
  output logic [N-1:0]   wstrb,
  output logic           wvalid,
  input  logic           wready,
  input  logic [1:0]     bresp,
  input  logic           bvalid,
  output logic           bready,
  output logic [A-1:0]   araddr,
  output logic [2:0]     arprot,
  output logic           arvalid,
  input  logic           arready,
  input  logic [N*8-1:0] rdata,
  input  logic [1:0]     rresp,
  input  logic           rvalid,
  output logic           rready
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t          state_reg, state_next;
  logic            write_reg;
  logic [A-1:0]    addr_reg;
  logic [N*8-1:0]  wdata_reg;
  logic [N-1:0]    wstrb_reg;
  logic            aw_pend_reg, w_pend_reg;
  logic [N*8-1:0]  rdata_reg;
  axi4_lite_resp_t resp_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // AW and W retire independently; leave WR once neither is still pending.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cmd_ready = ~areset;
        if (cmd_valid) state_next = cmd_write ? WR : RA;
      end
      WR: begin
        awvalid = aw_pend_reg;
        wvalid  = w_pend_reg;
        if ((!aw_pend_reg || awready) && (!w_pend_reg || wready)) state_next = WB;
      end
      WB: begin
        bready = 1'b1;
        if (bvalid) state_next = RSP;
      end
      RA: begin
        arvalid = 1'b1;
        if (arready) state_next = RD;
      end
      RD: begin
        rready = 1'b1;
        if (rvalid) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      aw_pend_reg <= 1'b0;
      w_pend_reg  <= 1'b0;
      rdata_reg   <= '0;
      resp_reg    <= OKAY;
    end else begin
      unique case (state_reg)
        IDLE: if (cmd_valid) begin
          write_reg   <= cmd_write;
          addr_reg    <= cmd_addr;
          wdata_reg   <= cmd_wdata;
          wstrb_reg   <= cmd_wstrb;
          aw_pend_reg <= cmd_write;
          w_pend_reg  <= cmd_write;
          rdata_reg   <= '0;
          resp_reg    <= OKAY;
        end
        WR: begin
          if (awready) aw_pend_reg <= 1'b0;
          if (wready)  w_pend_reg  <= 1'b0;
        end
        WB: if (bvalid) resp_reg <= bresp;
        RD: if (rvalid) begin
          rdata_reg <= rdata;
          resp_reg  <= rresp;
        end
        default: ;
      endcase
    end
  end

  assign awaddr    = addr_reg;
  assign araddr    = addr_reg;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wdata     = wdata_reg;
  assign wstrb     = wstrb_reg;
  assign rsp_write = write_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_resp  = resp_reg;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Randomized scoreboard bench for axi4_lite_cmd_master against a register-file style
// slave stub with random ready/response delays.
module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  localparam logic [31:0] MAGIC = 32'hb19b00b5;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi4_lite_cmd_master #(.A(16), .N(4)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- slave stub: 16 words, word 15 reads a constant ----------------
  logic [31:0] slv_mem [16];
  int   dmax = 0, bdmax = 0;
  bit   b_stall = 0;
  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int   b_dly = 0, r_dly = 0;
  logic b_pend, r_pend, aw_got, w_got;
  logic [15:0] aw_q;
  logic [31:0] wd_q;
  logic [3:0]  ws_q;
  int   aw_n, w_n, b_n, ar_n, r_n;

  wire        aw_hs   = awvalid & awready;
  wire        w_hs    = wvalid & wready;
  wire        ar_hs   = arvalid & arready;
  wire        aw_done = aw_got | aw_hs;
  wire        w_done  = w_got | w_hs;
  wire [15:0] wa      = aw_got ? aw_q : awaddr;
  wire [31:0] wd      = w_got ? wd_q : wdata;
  wire [3:0]  ws      = w_got ? ws_q : wstrb;

  initial for (int i = 0; i < 16; i++) slv_mem[i] = '0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; rvalid <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
      aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
    end else begin
      if (aw_hs) begin
        awready <= 0; aw_cnt <= $urandom_range(0, dmax); aw_got <= 1; aw_q <= awaddr;
      end else if (aw_cnt != 0) begin
        if (awvalid) aw_cnt <= aw_cnt - 1;
      end else awready <= 1;
      if (w_hs) begin
        wready <= 0; w_cnt <= $urandom_range(0, dmax); w_got <= 1; wd_q <= wdata; ws_q <= wstrb;
      end else if (w_cnt != 0) begin
        if (wvalid) w_cnt <= w_cnt - 1;
      end else wready <= 1;
      if (aw_done && w_done) begin
        aw_got <= 0; w_got <= 0;
        if (wa < 16'h40) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) slv_mem[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
        end
        bresp <= (wa < 16'h40) ? OKAY : SLVERR;
        if (b_stall) begin b_pend <= 1; b_cnt <= 100000; end
        else if (b_dly == 0) bvalid <= 1;
        else begin b_pend <= 1; b_cnt <= b_dly; end
        b_dly <= $urandom_range(0, bdmax);
      end
      if (b_pend) begin
        if (b_cnt == 1) begin bvalid <= 1; b_pend <= 0; end
        else b_cnt <= b_cnt - 1;
      end
      if (bvalid && bready) bvalid <= 0;
      if (ar_hs) begin
        arready <= 0; ar_cnt <= $urandom_range(0, dmax);
        if (araddr >= 16'h40) begin rdata <= 32'hdead0000 | {16'h0, araddr}; rresp <= DECERR; end
        else begin rdata <= (araddr[5:2] == 4'd15) ? MAGIC : slv_mem[araddr[5:2]]; rresp <= OKAY; end
        if (r_dly == 0) rvalid <= 1;
        else begin r_pend <= 1; r_cnt <= r_dly; end
        r_dly <= $urandom_range(0, bdmax);
      end else if (ar_cnt != 0) begin
        if (arvalid) ar_cnt <= ar_cnt - 1;
      end else arready <= 1;
      if (r_pend) begin
        if (r_cnt == 1) begin rvalid <= 1; r_pend <= 0; end
        else r_cnt <= r_cnt - 1;
      end
      if (rvalid && rready) rvalid <= 0;
      if (cmd_valid && cmd_ready) begin
        aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
      end else begin
        if (aw_hs) aw_n <= aw_n + 1;
        if (w_hs) w_n <= w_n + 1;
        if (bvalid && bready) b_n <= b_n + 1;
        if (ar_hs) ar_n <= ar_n + 1;
        if (rvalid && rready) r_n <= r_n + 1;
      end
    end
  end

  // ---------------- reference model: word array with byte-masked writes ----------------
  logic [31:0]    model_mem [16];
  axi4_lite_rsp_t exp_q [$];

  task automatic model_issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, output axi4_lite_rsp_t r);
    logic [31:0] mask;
    bit in_range;
    int idx;
    in_range = (a < 16'h40);
    idx = int'(a) / 4;
    r.write = w;
    r.rdata = 32'h0;
    if (w) begin
      r.resp = in_range ? OKAY : SLVERR;
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hff << (8 * b));
      if (in_range) model_mem[idx] = (model_mem[idx] & ~mask) | (d & mask);
    end else if (!in_range) begin
      r.resp = DECERR;
      r.rdata = 32'hdead0000 + 32'(a);
    end else begin
      r.resp = OKAY;
      r.rdata = (idx == 15) ? MAGIC : model_mem[idx];
    end
  endtask

  // ---------------- monitor: pops expectations on every response handshake ----------------
  initial begin
    axi4_lite_rsp_t e;
    bit after_hs = 0, hold_prev = 0, aw_prev = 0, w_prev = 0, ar_prev = 0;
    logic [35:0] rsp_save;
    logic [15:0] aw_save, ar_save;
    logic [35:0] w_save;
    forever begin
      @(negedge aclk);
      if (areset) begin
        after_hs = 0; hold_prev = 0; aw_prev = 0; w_prev = 0; ar_prev = 0;
      end else begin
        if (after_hs) chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        if (hold_prev)
          chk("rsp_stable", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp}), 64'({1'b1, rsp_save[34:0]}));
        if (rsp_valid)
          chk("rsp_bus_quiet", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        if (aw_prev) chk("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, aw_save}));
        if (w_prev)  chk("w_stable", 64'({wvalid, wdata, wstrb}), 64'({1'b1, w_save[35:0]}));
        if (ar_prev) chk("ar_stable", 64'({arvalid, araddr}), 64'({1'b1, ar_save}));
        if (awvalid | arvalid)
          chk("prot_zero", 64'({awprot, arprot}), 64'd0);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_write", 64'(rsp_write), 64'(e.write));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            chk("hs_counts", 64'({aw_n[3:0], w_n[3:0], b_n[3:0], ar_n[3:0], r_n[3:0]}),
                e.write ? 64'h11100 : 64'h00011);
          end
        end
        after_hs  = rsp_valid && rsp_ready;
        hold_prev = rsp_valid && !rsp_ready;
        rsp_save  = {rsp_valid, rsp_write, rsp_rdata, rsp_resp};
        aw_prev   = awvalid && !awready;  aw_save = awaddr;
        w_prev    = wvalid && !wready;    w_save  = {wvalid, wdata, wstrb};
        ar_prev   = arvalid && !arready;  ar_save = araddr;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, input bit chk_lat);
    axi4_lite_rsp_t e;
    int n, t0;
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    rsp_ready = (hold == 0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 0;
      return;
    end
    model_issue(w, a, d, s, e);
    exp_q.push_back(e);
    @(posedge aclk); #1;
    t0 = cyc;
    cmd_valid = 0; cmd_addr = 16'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    n = 0;
    do begin @(negedge aclk); n++; end while (!rsp_valid && n < 300);
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge aclk);
      @(posedge aclk); #1;
      rsp_ready = 1;
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    rsp_ready = 0;
    if (chk_lat) chk("latency", 64'(cyc - t0), 64'd3);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    axi4_lite_rsp_t junk;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid,
                              rsp_write, rsp_rdata, rsp_resp}), 64'd0);
    areset = 0;
    repeat (2) @(posedge aclk);

    // zero-wait slave: directed cases with latency checks
    run_cmd(1'b0, 16'h003c, 32'h0, 4'h0, 0, 1);
    run_cmd(1'b1, 16'h0004, 32'habbabeef, 4'hf, 0, 1);
    run_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 0, 1);
    run_cmd(1'b1, 16'h0004, 32'h00001234, 4'b0011, 0, 1);
    run_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 0, 1);
    run_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 5, 0);
    run_cmd(1'b1, 16'h0008, 32'h55aa33cc, 4'b1010, 5, 0);
    run_cmd(1'b0, 16'h0080, 32'h0, 4'h0, 0, 1);
    run_cmd(1'b1, 16'h0044, 32'h12345678, 4'hf, 2, 0);
    run_cmd(1'b0, 16'h0008, 32'h0, 4'h0, 0, 1);

    // random delays: AW/W in either order, delayed B/R, back-pressured responses
    dmax = 4; bdmax = 3;
    for (int i = 0; i < 60; i++) begin
      run_cmd(1'($urandom), 16'($urandom_range(0, 19) * 4), $urandom, 4'($urandom),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)), 0);
    end

    // reset while waiting for B
    dmax = 0; bdmax = 0; b_stall = 1;
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h000c; cmd_wdata = 32'hcafef00d; cmd_wstrb = 4'hf;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 100);
    chk("reset_cmd_accept", 64'(cmd_ready), 64'd1);
    model_issue(1'b1, 16'h000c, 32'hcafef00d, 4'hf, junk);
    @(posedge aclk); #1;
    cmd_valid = 0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bready && n < 100);
    chk("reach_wb", 64'(bready), 64'd1);
    @(posedge aclk); #2;
    areset = 1;
    #1;
    chk("reset_mid_wb", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid,
                             rsp_write, rsp_rdata, rsp_resp}), 64'd0);
    b_stall = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;
    @(negedge aclk);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    run_cmd(1'b0, 16'h003c, 32'h0, 4'h0, 0, 0);
    run_cmd(1'b0, 16'h000c, 32'h0, 4'h0, 1, 0);

    repeat (3) @(posedge aclk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
